branch_resolve_unit: RTL

//  Execute-side companion to the 2-bit bimodal predictor. Holds one record per predicted

---
 rtl/bp_defs.sv | 23 ++
 rtl/bp_pred_fifo.sv | 59 +++++
 rtl/branch_resolve_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bp_defs.sv
// Shared definitions for the branch resolve unit: widths, prediction record layout
// and the sequential-pc step.
package bp_defs;

   localparam int BP_XLEN = 32;

   // Packed record layout, LSB first: isbra, target, taken, pc
   localparam int REC_ISBRA_BIT  = 0;
   localparam int REC_TARGET_LSB = 1;
   localparam int REC_TAKEN_BIT  = BP_XLEN + 1;
   localparam int REC_PC_LSB     = BP_XLEN + 2;
   localparam int REC_W          = 2 * BP_XLEN + 2;

   localparam logic [BP_XLEN-1:0] PC_STEP = BP_XLEN'(4);

   typedef struct packed {
      logic [BP_XLEN-1:0] pc;
      logic               taken;
      logic [BP_XLEN-1:0] target;
      logic               isbra;
   } pred_rec_t;

endpackage

// File: rtl/bp_pred_fifo.sv
// In-order queue of prediction records; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate occupancy counter.
module bp_pred_fifo
   import bp_defs::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  logic      clear,
   input  pred_rec_t wdata,
   output pred_rec_t rdata,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   pred_rec_t   mem_r [DEPTH];
   logic [AW:0] wptr_r;
   logic [AW:0] rptr_r;

   // Pointer state; clear discards every queued record at once
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wptr_r <= '0;
         rptr_r <= '0;
      end else begin
         if (push) begin
            wptr_r <= wptr_r + PTR_ONE;
         end else begin
            wptr_r <= wptr_r;
         end
         if (pop) begin
            rptr_r <= rptr_r + PTR_ONE;
         end else begin
            rptr_r <= rptr_r;
         end
      end
   end

   // Record storage; contents are don't-care while the pointers say empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wptr_r[AW-1:0]] <= wdata;
      end
   end

   // Head read and occupancy flags
   always_comb begin
      rdata = mem_r[rptr_r[AW-1:0]];
      empty = (wptr_r == rptr_r);
      full  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks each in-flight prediction against the EX outcome and produces registered
// predictor-update and flush/redirect strobes plus performance counters.
module branch_resolve_unit
   import bp_defs::*;
#(
   parameter int XLEN  = BP_XLEN,
   parameter int DEPTH = 4,
   parameter int CNTW  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push_valid,
   output logic            push_ready,
   input  logic [XLEN-1:0] push_pc,
   input  logic            push_taken,
   input  logic [XLEN-1:0] push_target,
   input  logic            push_isbra,
   input  logic            res_valid,
   input  logic            res_taken,
   input  logic [XLEN-1:0] res_target,
   output logic            flush,
   output logic [XLEN-1:0] redirect_pc,
   output logic            update_en,
   output logic            actual_taken,
   output logic [XLEN-1:0] upd_pc,
   output logic            underflow_err,
   output logic [CNTW-1:0] br_count,
   output logic [CNTW-1:0] mp_count
);

   pred_rec_t       push_rec_s;
   pred_rec_t       head_rec_s;
   logic            fifo_full_s;
   logic            fifo_empty_s;
   logic            do_res_s;
   logic            mispredict_s;
   logic            push_acc_s;
   logic            pop_s;
   logic [XLEN-1:0] next_pc_s;

   logic            flush_r;
   logic [XLEN-1:0] redirect_pc_r;
   logic            update_en_r;
   logic            actual_taken_r;
   logic [XLEN-1:0] upd_pc_r;
   logic            underflow_err_r;
   logic [CNTW-1:0] br_count_r;
   logic [CNTW-1:0] mp_count_r;

   bp_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_acc_s),
      .pop   (pop_s),
      .clear (mispredict_s),
      .wdata (push_rec_s),
      .rdata (head_rec_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Compare the head record with the outcome and decide queue movement
   always_comb begin
      push_rec_s   = '{pc: push_pc, taken: push_taken, target: push_target, isbra: push_isbra};
      do_res_s     = res_valid && !fifo_empty_s;
      mispredict_s = 1'b0;
      if (do_res_s) begin
         mispredict_s = (res_taken != head_rec_s.taken) ||
                        (res_taken && (res_target != head_rec_s.target));
      end else begin
         mispredict_s = 1'b0;
      end
      // A correct resolve frees the head slot, so a full queue may still take a push
      pop_s      = do_res_s && !mispredict_s;
      push_acc_s = push_valid && !mispredict_s && (!fifo_full_s || do_res_s);
      next_pc_s  = res_taken ? res_target : (head_rec_s.pc + PC_STEP);
   end

   // Output strobes, resolved-outcome registers, counters and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_r         <= 1'b0;
         redirect_pc_r   <= '0;
         update_en_r     <= 1'b0;
         actual_taken_r  <= 1'b0;
         upd_pc_r        <= '0;
         underflow_err_r <= 1'b0;
         br_count_r      <= '0;
         mp_count_r      <= '0;
      end else begin
         flush_r         <= mispredict_s;
         update_en_r     <= do_res_s && head_rec_s.isbra;
         underflow_err_r <= underflow_err_r || (res_valid && fifo_empty_s);
         if (do_res_s) begin
            redirect_pc_r  <= next_pc_s;
            actual_taken_r <= res_taken;
            upd_pc_r       <= head_rec_s.pc;
            br_count_r     <= br_count_r + CNTW'(1);
            mp_count_r     <= mp_count_r + CNTW'(mispredict_s);
         end else begin
            redirect_pc_r  <= redirect_pc_r;
            actual_taken_r <= actual_taken_r;
            upd_pc_r       <= upd_pc_r;
            br_count_r     <= br_count_r;
            mp_count_r     <= mp_count_r;
         end
      end
   end

   assign push_ready    = !fifo_full_s;
   assign flush         = flush_r;
   assign redirect_pc   = redirect_pc_r;
   assign update_en     = update_en_r;
   assign actual_taken  = actual_taken_r;
   assign upd_pc        = upd_pc_r;
   assign underflow_err = underflow_err_r;
   assign br_count      = br_count_r;
   assign mp_count      = mp_count_r;

endmodule
